// File: rtl/board_equiv_checker.sv
// Sweeps a stimulus vector through NCHAN DUT channels and compares each against channel 0.
// Tracks a saturating error count, the first failing vector and the completed sweeps.
module board_equiv_checker #(
  parameter int unsigned VEC_W      = 8,
  parameter int unsigned NCHAN      = 3,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned STEP_CYC   = 50_000_000,
  parameter int unsigned ERR_W      = 4,
  parameter int unsigned MAXERROR   = 9,
  parameter int unsigned LOOP       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_mode,
  input  logic             stop_on_err,
  input  logic             step_btn,
  input  logic [NCHAN-1:0] inject,
  input  logic [NCHAN-1:0] dut_out,
  output logic [VEC_W-1:0] vec,
  output logic [ERR_W-1:0] err_count,
  output logic [NCHAN-1:0] mismatch_mask,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_vld,
  output logic [7:0]       sweep_cnt,
  output logic             check_pulse,
  output logic             done
);

  localparam int unsigned TmrMax = (SETTLE_CYC > STEP_CYC) ? SETTLE_CYC : STEP_CYC;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam logic [TmrW-1:0]  SettleLast = TmrW'(SETTLE_CYC - 1);
  localparam logic [TmrW-1:0]  StepLast   = TmrW'(STEP_CYC - 1);
  localparam logic [ERR_W-1:0] MaxErr     = ERR_W'(MAXERROR);

  typedef enum logic [2:0] {StApply, StCheck, StHold, StDone, StHalt} state_e;

  state_e           state_q, state_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [NCHAN-1:0] mask_q, mask_d;
  logic [VEC_W-1:0] ffv_q, ffv_d;
  logic             vld_q, vld_d;
  logic [7:0]       sweep_q, sweep_d;
  logic             btn_q, btn_d;

  logic [NCHAN-1:0] obs, mis_mask;
  logic             any_mis, step_rise, vec_max, hold_exit;

  always_comb begin
    obs       = inject | dut_out;
    mis_mask  = obs ^ {NCHAN{obs[0]}};
    any_mis   = |mis_mask;
    step_rise = step_btn & ~btn_q;
    vec_max   = (vec_q == '1);
    // step_mode is re-evaluated every HOLD cycle, so a mode change takes effect immediately
    hold_exit = step_mode ? step_rise : (tmr_q >= StepLast);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StApply;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StApply: if (tmr_q >= SettleLast) state_d = StCheck;
      StCheck: state_d = (any_mis && stop_on_err) ? StHalt : StHold;
      StHold: begin
        if (hold_exit) state_d = (vec_max && (LOOP == 0)) ? StDone : StApply;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      mask_q  <= '0;
      ffv_q   <= '0;
      vld_q   <= 1'b0;
      sweep_q <= '0;
      btn_q   <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      ffv_q   <= ffv_d;
      vld_q   <= vld_d;
      sweep_q <= sweep_d;
      btn_q   <= btn_d;
    end
  end

  always_comb begin
    tmr_d   = tmr_q;
    vec_d   = vec_q;
    err_d   = err_q;
    mask_d  = mask_q;
    ffv_d   = ffv_q;
    vld_d   = vld_q;
    sweep_d = sweep_q;
    btn_d   = step_btn;
    case (state_q)
      StApply: tmr_d = (tmr_q >= SettleLast) ? '0 : tmr_q + 1'b1;
      StCheck: begin
        tmr_d  = '0;
        mask_d = mis_mask;
        if (any_mis) begin
          if (err_q != MaxErr) err_d = err_q + 1'b1;
          if (!vld_q) begin
            ffv_d = vec_q;
            vld_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (hold_exit) begin
          tmr_d = '0;
          if (vec_max) begin
            sweep_d = sweep_q + 8'd1;
            if (LOOP != 0) vec_d = '0;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end else if (!step_mode) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    check_pulse = (state_q == StCheck);
    done        = (state_q == StDone) || (state_q == StHalt);
  end

  assign vec            = vec_q;
  assign err_count      = err_q;
  assign mismatch_mask  = mask_q;
  assign first_fail_vec = ffv_q;
  assign first_fail_vld = vld_q;
  assign sweep_cnt      = sweep_q;

endmodule

// File: tb/tb_board_equiv_checker.sv
// Directed bench for board_equiv_checker: scoreboard of expected check results per vector,
// plus a LOOP=0 instance run alongside the first sweep.
module tb_board_equiv_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_mode = 1'b0;
  logic       stop_on_err = 1'b0;
  logic       step_btn = 1'b0;
  logic [2:0] inject = 3'b000;
  logic [2:0] dut_out;
  logic [2:0] vec;
  logic [3:0] err_count;
  logic [2:0] mismatch_mask;
  logic [2:0] first_fail_vec;
  logic       first_fail_vld;
  logic [7:0] sweep_cnt;
  logic       check_pulse;
  logic       done;

  logic [2:0] inj_nl = 3'b000;
  logic [2:0] dut_out_nl;
  logic [2:0] vec_nl;
  logic [3:0] err_nl;
  logic [2:0] mask_nl;
  logic [2:0] ffv_nl;
  logic       vld_nl;
  logic [7:0] sweep_nl;
  logic       chk_nl;
  logic       done_nl;

  int mode = 0;  // 0: all channels = vec[0]; 1: ch2 inverted at vec==5
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] vec;
    logic [2:0] mask;
    logic [3:0] err;
    logic       vld;
    logic [2:0] ffv;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic pend = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    dut_out = {3{vec[0]}};
    if (mode == 1 && vec == 3'd5) dut_out[2] = ~vec[0];
    dut_out_nl = {3{vec_nl[0]}};
  end

  board_equiv_checker #(
    .VEC_W(3), .NCHAN(3), .SETTLE_CYC(2), .STEP_CYC(4), .ERR_W(4), .MAXERROR(9), .LOOP(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .step_mode(step_mode), .stop_on_err(stop_on_err),
    .step_btn(step_btn), .inject(inject), .dut_out(dut_out), .vec(vec),
    .err_count(err_count), .mismatch_mask(mismatch_mask), .first_fail_vec(first_fail_vec),
    .first_fail_vld(first_fail_vld), .sweep_cnt(sweep_cnt), .check_pulse(check_pulse),
    .done(done)
  );

  board_equiv_checker #(
    .VEC_W(3), .NCHAN(3), .SETTLE_CYC(2), .STEP_CYC(4), .ERR_W(4), .MAXERROR(9), .LOOP(0)
  ) u_dut_nl (
    .clk(clk), .rst_n(rst_n), .step_mode(step_mode), .stop_on_err(stop_on_err),
    .step_btn(step_btn), .inject(inj_nl), .dut_out(dut_out_nl), .vec(vec_nl),
    .err_count(err_nl), .mismatch_mask(mask_nl), .first_fail_vec(ffv_nl),
    .first_fail_vld(vld_nl), .sweep_cnt(sweep_nl), .check_pulse(chk_nl),
    .done(done_nl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // vec is compared during CHECK; the registered results one cycle later
  always @(negedge clk) begin
    if (pend) begin
      chk("sb_mask", mismatch_mask, cur.mask);
      chk("sb_err", err_count, cur.err);
      chk("sb_vld", first_fail_vld, cur.vld);
      chk("sb_ffv", first_fail_vec, cur.ffv);
      pend = 1'b0;
    end
    if (check_pulse && sb.size() > 0) begin
      cur = sb.pop_front();
      chk("sb_vec", vec, cur.vec);
      pend = 1'b1;
    end
  end

  task automatic push(input int v, input int m, input int e, input int vl, input int f);
    exp_t x;
    x.vec  = v[2:0];
    x.mask = m[2:0];
    x.err  = e[3:0];
    x.vld  = vl[0];
    x.ffv  = f[2:0];
    sb.push_back(x);
  endtask

  // Model for inject[2]=1 with all raw channels equal: even vectors mismatch on ch2
  task automatic push_inject(input int n);
    int err = 0;
    for (int i = 0; i < n; i++) begin
      int v = i % 8;
      bit e = (v % 2 == 0);
      if (e && err < 9) err++;
      push(v, e ? 4 : 0, err, 1, 0);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || pend) && n < budget) begin
      cyc(1);
      n++;
    end
    chk("sb_drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    chk("rst_vec", vec, 0);
    chk("rst_err", err_count, 0);
    chk("rst_mask", mismatch_mask, 0);
    chk("rst_vld", first_fail_vld, 0);
    chk("rst_ffv", first_fail_vec, 0);
    chk("rst_sweep", sweep_cnt, 0);
    chk("rst_chk", check_pulse, 0);
    chk("rst_done", done, 0);
  endtask

  initial begin
    int n;
    cyc(1);

    // Sweep with all channels equal, LOOP=1 and LOOP=0 side by side
    mode = 0;
    inject = 3'b000;
    do_reset();
    for (int v = 0; v < 8; v++) push(v, 0, 0, 0, 0);
    rst_n = 1'b1;
    wait_drain(100);
    n = 0;
    while (sweep_cnt != 8'd1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("t1_sweep", sweep_cnt, 1);
    chk("t1_vec_wrap", vec, 0);
    chk("t1_err", err_count, 0);
    chk("t1_vld", first_fail_vld, 0);
    chk("t5_done", done_nl, 1);
    chk("t5_sweep", sweep_nl, 1);
    chk("t5_vec", vec_nl, 7);
    cyc(20);
    chk("t5_vec_hold", vec_nl, 7);
    chk("t5_done_hold", done_nl, 1);
    chk("t5_sweep_hold", sweep_nl, 1);

    // Injected ch2 fault: even vectors fail, count saturates at 9 in sweep 3
    do_reset();
    inject = 3'b100;
    push_inject(24);
    rst_n = 1'b1;
    wait_drain(24 * 7 + 40);
    chk("t2_err_sat", err_count, 9);
    inject = 3'b000;

    // Stop on the first mismatch at vec 5
    do_reset();
    mode = 1;
    stop_on_err = 1'b1;
    for (int v = 0; v < 5; v++) push(v, 0, 0, 0, 0);
    push(5, 4, 1, 1, 5);
    rst_n = 1'b1;
    wait_drain(80);
    n = 0;
    while (!done && n < 20) begin
      cyc(1);
      n++;
    end
    chk("t3_done", done, 1);
    chk("t3_vec", vec, 5);
    chk("t3_err", err_count, 1);
    cyc(100);
    chk("t3_vec_hold", vec, 5);
    chk("t3_err_hold", err_count, 1);
    chk("t3_done_hold", done, 1);
    chk("t3_chk_low", check_pulse, 0);

    // Single-step mode
    do_reset();
    mode = 0;
    stop_on_err = 1'b0;
    step_mode = 1'b1;
    push(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    wait_drain(20);
    cyc(1000);
    chk("t4_no_adv", vec, 0);
    chk("t4_not_done", done, 0);
    push(1, 0, 0, 0, 0);
    step_btn = 1'b1;
    cyc(1);
    chk("t4_step_adv", vec, 1);
    step_btn = 1'b0;
    cyc(1);
    step_btn = 1'b1;  // pulse while in APPLY
    cyc(1);
    step_btn = 1'b0;
    wait_drain(20);
    cyc(50);
    chk("t4_apply_ignored", vec, 1);
    step_mode = 1'b0;

    // Reset in the middle of HOLD at vec 3 with two errors logged
    do_reset();
    inject = 3'b100;
    push_inject(4);
    rst_n = 1'b1;
    wait_drain(60);
    chk("t6_pre_vec", vec, 3);
    chk("t6_pre_err", err_count, 2);
    rst_n = 1'b0;
    cyc(1);
    chk("t6_vec", vec, 0);
    chk("t6_err", err_count, 0);
    chk("t6_vld", first_fail_vld, 0);
    chk("t6_done", done, 0);
    chk("t6_mask", mismatch_mask, 0);
    inject = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
